tlk2711_axil_reg_bridge: RTL
============================

Name: tlk2711_axil_reg_bridge

Overview:
- AXI4-Lite slave (32-bit data) that drives the 64-bit register port of tlk2711_top: i_reg_wen/waddr/wdata, i_reg_ren/raddr, o_reg_rdata.
- Sits between the PS master port and tlk2711_top.
- Splits each 64-bit register into low word (offset +0) and high word (offset +4).
- A high-word write commits the full 64-bit register. A low-word read samples all 64 bits, so read-side-effect registers (IRQ status) are touched once per 64-bit read.

Parameters:
- AXI_ADDR_WIDTH, 16, s_axi address width.
- REG_ADDR_WIDTH, 16, register address width; must be <= AXI_ADDR_WIDTH.
- RD_LATENCY, 1, cycles from o_reg_ren to i_reg_rdata valid; range 1..3.

Ports:
- clk  in  1  clock; the block uses this single clock.
- rst  in  1  reset, synchronous, active-high.
- s_axi_awaddr in AXI_ADDR_WIDTH; s_axi_awvalid in 1; s_axi_awready out 1
- s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1
- s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1
- s_axi_araddr in AXI_ADDR_WIDTH; s_axi_arvalid in 1; s_axi_arready out 1
- s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1
- o_reg_wen out 1; o_reg_waddr out REG_ADDR_WIDTH; o_reg_wdata out 64  (to tlk2711_top i_reg_w*)
- o_reg_ren out 1; o_reg_raddr out REG_ADDR_WIDTH; i_reg_rdata in 64  (to/from tlk2711_top)

Behaviour:
- Reset values: all outputs 0. Shadow words and high-read latch 0.
- awready, wready and arready rise the first cycle after rst deasserts.
- Word select = addr[2]. Register address = addr[REG_ADDR_WIDTH-1:0] with bits [2:0] forced to 0. addr[1:0] is ignored.
- Write FSM, states WR_IDLE, WR_EXEC, WR_RESP:
  - WR_IDLE: AW and W are accepted independently, in either order. Each ready drops after its handshake; the other channel is still awaited. Go to WR_EXEC once both are held.
  - WR_EXEC (1 cycle): wstrb byte-merges wdata into shadow_lo (word 0) or shadow_hi (word 1).
  - If word 1: o_reg_wen=1 for exactly one cycle, o_reg_waddr = register address, o_reg_wdata = {merged shadow_hi, shadow_lo}. Word 0 alone produces no o_reg_wen.
  - WR_RESP: bvalid=1, bresp=2'b00. Hold until bready, then WR_IDLE with awready and wready high again.
  - Write latency: AW/W handshake -> o_reg_wen is 1 cycle; bvalid follows 1 cycle after o_reg_wen.
  - Shadows are not cleared after commit; they persist until overwritten.
- Read FSM, states RD_IDLE, RD_WAIT, RD_RESP:
  - RD_IDLE: arready=1. On handshake go to RD_WAIT.
  - Word 0: o_reg_ren=1 for one cycle with o_reg_raddr = register address. Wait RD_LATENCY cycles, then capture i_reg_rdata. Low 32 bits go to rdata; high 32 bits go to hi_latch.
  - Word 1: no o_reg_ren. rdata = hi_latch, RD_WAIT skipped.
  - RD_RESP: rvalid=1, rresp=2'b00. Hold rdata stable until rready, then RD_IDLE.
- Read and write FSMs run concurrently. o_reg_wen and o_reg_ren may assert in the same cycle.
- A word-1 read after a word-0 read of a different register returns that other register's high word. This is software's responsibility; no error response is issued.
- Same-cycle word-0 read and commit to the same register: the read returns the value tlk2711_top presents, pre- or post-write; no ordering is added.
- Backpressure: bvalid/rvalid held indefinitely. No new AW/W/AR is accepted on that channel until its response completes; at most one outstanding transaction per direction.
- rst mid-transaction: any pending response is abandoned. o_reg_wen/o_reg_ren clear the same cycle. Shadows and hi_latch return to 0.

Decomposition:
- Package tlk2711_bridge_pkg: write and read FSM state enums; RESP_OKAY=2'b00; WORD_SEL_BIT=2; 64-bit register map offsets: TX_ENA 0x0008, RX_ENA 0x0010, TX_BASE 0x0020, TX_PACKET 0x0030, RX_BASE 0x0040, RX_CTRL 0x0048, RX_STATUS 0x0050, RX_CTRL2 0x0058, IRQ 0x0060, IRQ_CTRL 0x0068.
- Sub-module tlk2711_bridge_wstage: AW/W capture and byte-merge shadows. Read path stays in the top.

Test Plan:
- Write 0x00000010 to 0x0068, then 0x10000000 to 0x006C -> no wen after first write; single o_reg_wen, waddr 0x0068, wdata 64'h1000_0000_0000_0010; two bvalid with bresp 0.
- W (0x3) presented 3 cycles before AW 0x0008, then high 0x0 to 0x000C -> o_reg_wen once, wdata 64'h3; awready/wready low between own handshake and bvalid.
- Low 0xAABBCCDD; high with wstrb 4'b0101, data 0x11223344, prior shadow_hi 0 -> wdata 64'h0022_0044_AABB_CCDD.
- i_reg_rdata = 64'h0123_4567_89AB_CDEF. Read 0x0050 -> one o_reg_ren, raddr 0x0050, rdata 0x89ABCDEF. Read 0x0054 -> no o_reg_ren, rdata 0x01234567. Repeat with RD_LATENCY=3.
- rready held low 10 cycles -> rvalid and rdata stable; arready low throughout. Concurrent write commit proceeds, o_reg_wen pulses during the stall.
- rst asserted in WR_RESP with bvalid=1 -> next cycle bvalid=0, all readies 0. After release, fresh high-only write to 0x000C -> wdata upper word = data, lower word = 0.

Source files
------------

// File: rtl/tlk2711_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to tlk2711 64-bit register bridge.
// Register offsets are the 64-bit register map of tlk2711_top.
package tlk2711_bridge_pkg;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_EXEC = 2'd1,
      WR_RESP = 2'd2
   } wr_state_e;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2
   } rd_state_e;

   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam int unsigned WORD_SEL_BIT = 2;

   localparam logic [15:0] REG_TX_ENA    = 16'h0008;
   localparam logic [15:0] REG_RX_ENA    = 16'h0010;
   localparam logic [15:0] REG_TX_BASE   = 16'h0020;
   localparam logic [15:0] REG_TX_PACKET = 16'h0030;
   localparam logic [15:0] REG_RX_BASE   = 16'h0040;
   localparam logic [15:0] REG_RX_CTRL   = 16'h0048;
   localparam logic [15:0] REG_RX_STATUS = 16'h0050;
   localparam logic [15:0] REG_RX_CTRL2  = 16'h0058;
   localparam logic [15:0] REG_IRQ       = 16'h0060;
   localparam logic [15:0] REG_IRQ_CTRL  = 16'h0068;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/tlk2711_axil_reg_bridge_if.sv
// AXI4-Lite bus (32-bit data) between the PS master port and the register bridge.
interface tlk2711_axil_reg_bridge_if #(
   parameter int unsigned AXI_ADDR_WIDTH = 16
);
   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic                      awvalid;
   logic                      awready;
   logic [31:0]               wdata;
   logic [3:0]                wstrb;
   logic                      wvalid;
   logic                      wready;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic                      arvalid;
   logic                      arready;
   logic [31:0]               rdata;
   logic [1:0]                rresp;
   logic                      rvalid;
   logic                      rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/tlk2711_bridge_wstage.sv
// AW/W capture and the low/high shadow words that assemble a 64-bit register write.
// Shadows persist across commits so a lone high-word write reuses the last low word.
module tlk2711_bridge_wstage
   import tlk2711_bridge_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 16,
   parameter int unsigned REG_ADDR_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      aw_fire,
   input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
   input  logic                      w_fire,
   input  logic [31:0]               wdata,
   input  logic [3:0]                wstrb,
   input  logic                      commit,
   output logic                      aw_held,
   output logic                      w_held,
   output logic                      word_sel,
   output logic [REG_ADDR_WIDTH-1:0] reg_addr,
   output logic [63:0]               reg_wdata
);

   logic [REG_ADDR_WIDTH-1:0] addr_q;
   logic                      word_q;
   logic [31:0]               data_q;
   logic [3:0]                strb_q;
   logic                      aw_held_q, w_held_q;
   logic [31:0]               shadow_lo_q, shadow_hi_q;
   logic [31:0]               merged;
   logic                      unused_awaddr;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         word_q      <= 1'b0;
         data_q      <= '0;
         strb_q      <= '0;
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         shadow_lo_q <= '0;
         shadow_hi_q <= '0;
      end else begin
         if (aw_fire) begin
            addr_q    <= {awaddr[REG_ADDR_WIDTH-1:3], 3'b000};
            word_q    <= awaddr[WORD_SEL_BIT];
            aw_held_q <= 1'b1;
         end
         if (w_fire) begin
            data_q   <= wdata;
            strb_q   <= wstrb;
            w_held_q <= 1'b1;
         end
         if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            if (word_q) shadow_hi_q <= merged;
            else        shadow_lo_q <= merged;
         end
      end
   end

   assign merged        = byte_merge(word_q ? shadow_hi_q : shadow_lo_q, data_q, strb_q);
   assign aw_held       = aw_held_q;
   assign w_held        = w_held_q;
   assign word_sel      = word_q;
   assign reg_addr      = addr_q;
   assign reg_wdata     = {merged, shadow_lo_q};
   assign unused_awaddr = ^awaddr;

endmodule

// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave driving the 64-bit tlk2711_top register port: high-word writes commit,
// low-word reads sample all 64 bits and park the upper half for the following high read.
module tlk2711_axil_reg_bridge
   import tlk2711_bridge_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 16,
   parameter int unsigned REG_ADDR_WIDTH = 16,
   parameter int unsigned RD_LATENCY     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   tlk2711_axil_reg_bridge_if.slave  s_axi,
   output logic                      o_reg_wen,
   output logic [REG_ADDR_WIDTH-1:0] o_reg_waddr,
   output logic [63:0]               o_reg_wdata,
   output logic                      o_reg_ren,
   output logic [REG_ADDR_WIDTH-1:0] o_reg_raddr,
   input  logic [63:0]               i_reg_rdata
);

   wr_state_e wr_q, wr_d;
   rd_state_e rd_q, rd_d;
   logic      ready_en_q;
   logic      aw_fire, w_fire, aw_held, w_held, word_sel;
   logic      ar_fire, ar_word, rd_capture;
   logic [1:0]                lat_cnt_q;
   logic                      ren_q;
   logic [REG_ADDR_WIDTH-1:0] raddr_q;
   logic [31:0]               rdata_q, hi_latch_q;
   logic                      unused_araddr;

   // Readies stay low during reset and rise one cycle after it releases.
   always_ff @(posedge clk) begin
      if (rst) ready_en_q <= 1'b0;
      else     ready_en_q <= 1'b1;
   end

   // ---------------- write path ----------------
   assign s_axi.awready = ready_en_q && (wr_q == WR_IDLE) && !aw_held;
   assign s_axi.wready  = ready_en_q && (wr_q == WR_IDLE) && !w_held;
   assign aw_fire       = s_axi.awvalid && s_axi.awready;
   assign w_fire        = s_axi.wvalid && s_axi.wready;

   tlk2711_bridge_wstage #(
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
   ) u_wstage (
      .clk      (clk),
      .rst      (rst),
      .aw_fire  (aw_fire),
      .awaddr   (s_axi.awaddr),
      .w_fire   (w_fire),
      .wdata    (s_axi.wdata),
      .wstrb    (s_axi.wstrb),
      .commit   (wr_q == WR_EXEC),
      .aw_held  (aw_held),
      .w_held   (w_held),
      .word_sel (word_sel),
      .reg_addr (o_reg_waddr),
      .reg_wdata(o_reg_wdata)
   );

   always_ff @(posedge clk) begin
      if (rst) wr_q <= WR_IDLE;
      else     wr_q <= wr_d;
   end

   always_comb begin
      wr_d = wr_q;
      unique case (wr_q)
         WR_IDLE: if ((aw_held || aw_fire) && (w_held || w_fire)) wr_d = WR_EXEC;
         WR_EXEC: wr_d = WR_RESP;
         WR_RESP: if (s_axi.bready) wr_d = WR_IDLE;
         default: wr_d = WR_IDLE;
      endcase
   end

   assign o_reg_wen    = (wr_q == WR_EXEC) && word_sel;
   assign s_axi.bvalid = (wr_q == WR_RESP);
   assign s_axi.bresp  = RESP_OKAY;

   // ---------------- read path ----------------
   assign s_axi.arready = ready_en_q && (rd_q == RD_IDLE);
   assign ar_fire       = s_axi.arvalid && s_axi.arready;
   assign ar_word       = s_axi.araddr[WORD_SEL_BIT];
   assign rd_capture    = (rd_q == RD_WAIT) && (lat_cnt_q == 2'(RD_LATENCY));
   assign unused_araddr = ^s_axi.araddr;

   always_comb begin
      rd_d = rd_q;
      unique case (rd_q)
         RD_IDLE: if (ar_fire) rd_d = ar_word ? RD_RESP : RD_WAIT;
         RD_WAIT: if (rd_capture) rd_d = RD_RESP;
         RD_RESP: if (s_axi.rready) rd_d = RD_IDLE;
         default: rd_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q       <= RD_IDLE;
         lat_cnt_q  <= '0;
         ren_q      <= 1'b0;
         raddr_q    <= '0;
         rdata_q    <= '0;
         hi_latch_q <= '0;
      end else begin
         rd_q      <= rd_d;
         ren_q     <= ar_fire && !ar_word;
         lat_cnt_q <= (rd_q == RD_WAIT) ? lat_cnt_q + 2'd1 : 2'd0;
         if (ar_fire && !ar_word) raddr_q <= {s_axi.araddr[REG_ADDR_WIDTH-1:3], 3'b000};
         if (ar_fire && ar_word)  rdata_q <= hi_latch_q;
         if (rd_capture) begin
            rdata_q    <= i_reg_rdata[31:0];
            hi_latch_q <= i_reg_rdata[63:32];
         end
      end
   end

   assign o_reg_ren    = ren_q;
   assign o_reg_raddr  = raddr_q;
   assign s_axi.rvalid = (rd_q == RD_RESP);
   assign s_axi.rresp  = RESP_OKAY;
   assign s_axi.rdata  = rdata_q;

endmodule
